// File: rtl/generation_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : generation_controller                                         |
// | Function : Sequencer for the Conway memory register and grid calculator. |
// |            Drives the memory write strobe and load/run source select,    |
// |            and owns the idle/load/run/single-step modes, the generation  |
// |            prescaler and the generation counter.                          |
// | Options  : GEN_LIMIT_EN - adds GEN_LIMIT input; free-running mode stops  |
// |            by itself once GEN_COUNT reaches a nonzero GEN_LIMIT.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module generation_controller #(
    parameter int COUNT_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    LOAD_REQ,
    input  logic                    START,
    input  logic                    STOP,
    input  logic                    STEP,
    input  logic [PERIOD_WIDTH-1:0] PERIOD,
`ifdef GEN_LIMIT_EN
    input  logic [COUNT_WIDTH-1:0]  GEN_LIMIT,
`endif
    output logic                    WRITE_ENABLE,
    output logic                    LOAD_RUN,
    output logic                    RUNNING,
    output logic [COUNT_WIDTH-1:0]  GEN_COUNT,
    output logic                    GEN_WRAP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] c_period_one = PERIOD_WIDTH'(1);
    localparam logic [COUNT_WIDTH:0]    c_count_one  = (COUNT_WIDTH+1)'(1);

    state_t                  state_q,     state_d;
    logic                    we_q,        we_d;
    logic                    load_run_q,  load_run_d;
    logic                    running_q,   running_d;
    logic [COUNT_WIDTH-1:0]  count_q,     count_d;
    logic                    wrap_q,      wrap_d;
    logic [PERIOD_WIDTH-1:0] presc_q,     presc_d;
    logic                    limit_hit_q, limit_hit_d;

    logic [PERIOD_WIDTH-1:0] w_reload;
    logic [COUNT_WIDTH-1:0]  w_count_inc;
    logic                    w_count_carry;
    logic                    w_limit_reached;
    logic                    w_load;
    logic                    w_bump;

    // Prescaler reload: a PERIOD of 0 behaves exactly like a PERIOD of 1.
    assign w_reload = (PERIOD == '0) ? '0 : (PERIOD - c_period_one);

    // Counter increment with carry-out; the carry marks a wrap to zero.
    assign {w_count_carry, w_count_inc} = {1'b0, count_q} + c_count_one;

`ifdef GEN_LIMIT_EN
    // The write about to happen lands exactly on a nonzero limit.
    assign w_limit_reached = (GEN_LIMIT != '0) && (w_count_inc == GEN_LIMIT);
`else
    assign w_limit_reached = 1'b0;
`endif

    // Next-state and next-output decode; requests ranked LOAD > STOP > STEP > START.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        count_d     = count_q;
        wrap_d      = wrap_q;
        presc_d     = presc_q;
        limit_hit_d = 1'b0;
        w_load      = 1'b0;
        w_bump      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (LOAD_REQ) begin
                    w_load = 1'b1;
                end else if (!STOP) begin
                    // STOP has no effect in IDLE but still outranks STEP/START.
                    if (STEP) begin
                        state_d = ST_STEP;
                        w_bump  = 1'b1;
                    end else if (START) begin
                        // First write lands max(PERIOD,1) edges from now.
                        state_d = ST_RUN;
                        presc_d = w_reload;
                    end
                end
            end

            ST_LOAD: begin
                // A load is always a single cycle, even with LOAD_REQ held.
                state_d = ST_IDLE;
            end

            ST_STEP: begin
                if (LOAD_REQ) begin
                    w_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (LOAD_REQ) begin
                    w_load = 1'b1;
                end else if (STOP || limit_hit_q) begin
                    // Any partial period is dropped; the next START is a full one.
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (presc_q == '0) begin
                    // Generation boundary: write, and pick up the current PERIOD.
                    w_bump      = 1'b1;
                    presc_d     = w_reload;
                    limit_hit_d = w_limit_reached;
                end else begin
                    presc_d = presc_q - c_period_one;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_load) begin
            state_d = ST_LOAD;
            we_d    = 1'b1;
            count_d = '0;
            wrap_d  = 1'b0;
            presc_d = '0;
        end

        if (w_bump) begin
            we_d    = 1'b1;
            count_d = w_count_inc;
            wrap_d  = wrap_q | w_count_carry;
        end
    end

    // Mode outputs follow the state being entered so they line up with the write strobe.
    assign running_d  = (state_d == ST_RUN);
    assign load_run_d = (state_d != ST_LOAD);

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            load_run_q  <= 1'b1;
            running_q   <= 1'b0;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            presc_q     <= '0;
            limit_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            load_run_q  <= load_run_d;
            running_q   <= running_d;
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            presc_q     <= presc_d;
            limit_hit_q <= limit_hit_d;
        end
    end

    assign WRITE_ENABLE = we_q;
    assign LOAD_RUN     = load_run_q;
    assign RUNNING      = running_q;
    assign GEN_COUNT    = count_q;
    assign GEN_WRAP     = wrap_q;

endmodule
`default_nettype wire
